// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and default widths for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LOCK_MAX = 16;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Processor, external-port and data-memory signals of the arbiter in one bundle.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_lock;
    logic              ext_gnt;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_addr, mem_data, mem_we, mem_re,
        input  mem_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_addr, mem_data, mem_we, mem_re,
        output mem_q
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; bit 0 = CPU, bit 1 = EXT.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = (last == OWN_EXT) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the processor and the external port,
// with optional bounded exclusive ownership for the external side.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    state_e            state, state_nxt;
    owner_e            last, last_nxt, last_eff;
    owner_e            rd_owner, rd_owner_nxt;
    logic              rd_pend, rd_pend_nxt;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;

    logic              forced_exit, lock_exit, arb_mode, conflict;
    logic [1:0]        req, pick, gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_we, sel_re;

    assign req         = {bus.ext_req, bus.cpu_req};
    assign forced_exit = (state == ST_LOCK) && (lock_cnt == CNT_MAX);
    assign lock_exit   = (state == ST_LOCK) &&
                         (!bus.ext_lock || !bus.ext_req || forced_exit);
    // An exit cycle is arbitrated normally; a forced exit hands the next conflict to the CPU.
    assign arb_mode    = (state == ST_ARB) || lock_exit;
    assign last_eff    = forced_exit ? OWN_EXT : last;
    assign conflict    = arb_mode && (&req);

    rr_pick2 u_pick (
        .req  (req),
        .last (last_eff),
        .gnt  (pick)
    );

    assign gnt = arb_mode ? pick : {bus.ext_req, 1'b0};

    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        lock_cnt_nxt = lock_cnt;
        rd_pend_nxt  = 1'b0;
        rd_owner_nxt = rd_owner;
        sel_addr     = '0;
        sel_data     = '0;
        sel_we       = 1'b0;
        sel_re       = 1'b0;

        if (conflict) begin
            last_nxt = gnt[1] ? OWN_EXT : OWN_CPU;
        end else if (forced_exit) begin
            last_nxt = OWN_EXT;
        end

        if (gnt[1] && bus.ext_lock) begin
            state_nxt    = ST_LOCK;
            lock_cnt_nxt = arb_mode ? CNT_W'(1)
                         : (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + CNT_W'(1);
        end else begin
            state_nxt    = ST_ARB;
            lock_cnt_nxt = '0;
        end

        if (gnt[0]) begin
            sel_addr = bus.cpu_addr;
            sel_data = bus.cpu_wdata;
            sel_we   = bus.cpu_we;
            sel_re   = !bus.cpu_we;
        end else if (gnt[1]) begin
            sel_addr = bus.ext_addr;
            sel_data = bus.ext_wdata;
            sel_we   = bus.ext_we;
            sel_re   = !bus.ext_we;
        end

        if (sel_re) begin
            rd_pend_nxt  = 1'b1;
            rd_owner_nxt = gnt[1] ? OWN_EXT : OWN_CPU;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_ARB;
            last     <= OWN_EXT;
            lock_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= OWN_CPU;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
            rd_pend  <= rd_pend_nxt;
            rd_owner <= rd_owner_nxt;
        end
    end

    assign bus.mem_addr   = sel_addr;
    assign bus.mem_data   = sel_data;
    assign bus.mem_we     = sel_we;
    assign bus.mem_re     = sel_re;
    assign bus.cpu_stall  = bus.cpu_req && !gnt[0];
    assign bus.ext_gnt    = gnt[1];
    assign bus.cpu_rdata  = bus.mem_q;
    assign bus.ext_rdata  = bus.mem_q;
    assign bus.cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
    assign bus.ext_rvalid = rd_pend && (rd_owner == OWN_EXT);

endmodule
